sram_scan_display: RTL

- Downstream consumer of the SRAM sort stage: once the sorter pulses completion, this block reads the sorted words back from SRAM one at a time.
- Each word is shown on the 7-segment displays for a programmable dwell time: two HEX digits for data, one for address.
- The block shares the SRAM bus with the sort stage through a req/gnt handshake. It touches the bus only while granted.

---
 rtl/sram_scan_if.sv | 23 ++
 rtl/sram_scan_display.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sram_scan_if.sv
// SRAM read-bus bundle shared with the sort stage: request/grant handshake
// plus the address, enables and read data of the word being fetched.
interface sram_scan_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic              bus_req;
  logic              bus_gnt;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_ce;
  logic              sram_oe;
  logic [DATA_W-1:0] sram_rdata;

  modport master (
    output bus_req, sram_addr, sram_ce, sram_oe,
    input  bus_gnt, sram_rdata
  );

  modport slave (
    input  bus_req, sram_addr, sram_ce, sram_oe,
    output bus_gnt, sram_rdata
  );
endinterface

// File: rtl/sram_scan_display.sv
// Post-sort display scanner: walks SRAM words 0..NUM_WORDS-1, reads each one
// while holding the bus grant, and shows data (two digits) and address (one
// digit) on active-low 7-segment displays for DWELL cycles per word.
module sram_scan_display #(
  parameter int ADDR_W    = 2,
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 4,
  parameter int READ_WAIT = 2,
  parameter int DWELL     = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  sram_scan_if.master       bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2
);

  localparam int WW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [WW-1:0]     WAIT_LAST  = WW'(READ_WAIT - 1);
  localparam logic [DW-1:0]     DWELL_LAST = DW'(DWELL - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_WORDS - 1);
  localparam logic [6:0]        BLANK      = 7'h7F;

  typedef enum logic [1:0] {IDLE, REQ, READ, SHOW} state_t;

  state_t            state, next;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [WW-1:0]     wait_cnt;
  logic [DW-1:0]     dwell_cnt;
  logic [DATA_W-1:0] latch;
  logic              valid;
  logic              capture, fin;
  logic              req_q, rd_q;
  logic [ADDR_W-1:0] addr_q;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h27;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
  endfunction

  // Enables follow the registered read phase but drop the same cycle the grant
  // is withdrawn, so the scanner never drives the bus it no longer owns.
  assign bus.bus_req   = req_q;
  assign bus.sram_addr = addr_q;
  assign bus.sram_ce   = rd_q & bus.bus_gnt;
  assign bus.sram_oe   = rd_q & bus.bus_gnt;

  // Next-state / word-index decode; stop wins over everything outside IDLE.
  always_comb begin
    next    = state;
    idx_n   = idx;
    capture = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          next  = REQ;
          idx_n = '0;
        end
      end
      REQ: begin
        if (stop)             next = IDLE;
        else if (bus.bus_gnt) next = READ;
      end
      READ: begin
        if (stop)              next = IDLE;
        else if (!bus.bus_gnt) next = REQ;
        else if (wait_cnt == WAIT_LAST) begin
          next    = SHOW;
          capture = 1'b1;
        end
      end
      SHOW: begin
        if (stop) next = IDLE;
        else if (dwell_cnt == DWELL_LAST) begin
          if (idx != LAST_IDX) begin
            idx_n = idx + ADDR_W'(1);
            next  = REQ;
          end else if (loop_en) begin
            idx_n = '0;
            next  = REQ;
          end else begin
            next = IDLE;
            fin  = 1'b1;
          end
        end
      end
      default: next = IDLE;
    endcase
  end

  // State, counters and registered bus/status outputs derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      dwell_cnt <= '0;
      req_q     <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      latch     <= '0;
      cur_addr  <= '0;
      valid     <= 1'b0;
    end else begin
      state     <= next;
      idx       <= idx_n;
      wait_cnt  <= (state == READ && next == READ) ? wait_cnt + WW'(1) : '0;
      dwell_cnt <= (state == SHOW && next == SHOW) ? dwell_cnt + DW'(1) : '0;
      req_q     <= (next == REQ) || (next == READ);
      rd_q      <= (next == READ);
      addr_q    <= idx_n;
      busy      <= (next != IDLE);
      done      <= fin;
      if (capture) begin
        latch    <= bus.sram_rdata;
        cur_addr <= idx;
        valid    <= 1'b1;
      end
    end
  end

  // Segment drivers: blank until the first word is captured, then track it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HEX0 <= BLANK;
      HEX1 <= BLANK;
      HEX2 <= BLANK;
    end else if (valid) begin
      HEX0 <= seg(latch[3:0]);
      HEX1 <= seg(latch[7:4]);
      HEX2 <= seg(4'(cur_addr));
    end
  end

endmodule
